// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM encoding and the request record for the memory front-end.
package mem_ctrl_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RSP} ctrl_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_req_ctrl_if.sv
// Command, response and memory-side signals of the request front-end.
interface mem_req_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  // controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_addr, rsp_rdata,
           mem_read, mem_write, mem_addr, mem_data_in, busy
  );

  // requester / memory side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
           mem_read, mem_write, mem_addr, mem_data_in, busy
  );
endinterface

// File: rtl/mem_req_fifo.sv
// In-order request buffer; DEPTH must be a power of two so pointers wrap for free.
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   i_push,
  input  mem_req_t               i_data,
  input  logic                   i_pop,
  output mem_req_t               o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_req_t             r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_push;
  logic                 w_pop;

  // a full FIFO refuses a push even when a pop happens in the same cycle
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // entry storage; no reset needed since only counted entries are ever read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mem_req_ctrl.sv
// Front-end for the 32x8 sync memory: buffers commands, issues one access at a time,
// returns read data on a one-cycle strobe.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_,
  mem_req_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  mem_req_t          w_req_in;
  mem_req_t          w_head;

  logic              r_mem_read,  w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_din,   w_mem_din_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [ADDR_W-1:0] r_rsp_addr,  w_rsp_addr_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

  assign w_req_in = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
  assign w_push   = bus.req_valid && !w_full;
  assign w_pop    = (r_state == IDLE) && !w_empty;

  mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .i_push  (w_push),
    .i_data  (w_req_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // state register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state: every access state lasts exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = w_head.write ? WR : RD;
      WR:      w_state_nxt = IDLE;
      RD:      w_state_nxt = RD_WAIT;
      RD_WAIT: w_state_nxt = RSP;
      RSP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // next values of the registered outputs; address/data hold when strobes are low
  always_comb begin
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;
    w_rsp_addr_nxt  = r_rsp_addr;
    w_rsp_rdata_nxt = r_rsp_rdata;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_mem_addr_nxt  = w_head.addr;
        w_mem_din_nxt   = w_head.wdata;
        w_mem_write_nxt = w_head.write;
        w_mem_read_nxt  = !w_head.write;
      end
      // memory data_out is valid the cycle after read was high
      RD_WAIT: begin
        w_rsp_rdata_nxt = bus.mem_data_out;
        w_rsp_addr_nxt  = r_mem_addr;
        w_rsp_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // output registers; reset drops strobes at once so an interrupted read never responds
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_din   <= w_mem_din_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_addr  <= w_rsp_addr_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign bus.req_ready   = !w_full;
  assign bus.busy        = (w_count != '0) || (r_state != IDLE);
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data_in = r_mem_din;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_addr    = r_rsp_addr;
  assign bus.rsp_rdata   = r_rsp_rdata;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural 32x8 sync memory.
module tb_mem_req_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus();
  mem_req_ctrl #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst_(rst_), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural memory: samples on posedge, data_out valid the cycle after read
  logic [7:0] mem [32];
  logic [7:0] mem_dout = 8'h00;
  logic       mem_init = 1'b1;
  assign bus.mem_data_out = mem_dout;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
      if (bus.mem_read)  mem_dout <= mem[bus.mem_addr];
    end
  end

  mem_req_t acc_q[$];
  mem_req_t rsp_q[$];
  int       wr_edges[$];
  int       rsp_edges[$];
  int       rsp_cnt = 0;
  int       last_hs = 0;
  logic [7:0] shadow [32];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: pops expectations whenever the DUT presents an access or a response
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_rsp = 1'b0;
  always @(negedge clk) begin : mon
    mem_req_t e;
    if (bus.mem_read || bus.mem_write) begin
      chk("strobe_excl", 32'(bus.mem_read & bus.mem_write), 0);
      if (bus.mem_write) chk("wr_width", 32'(prev_wr), 0);
      if (bus.mem_read)  chk("rd_width", 32'(prev_rd), 0);
      chk("acc_expected", 32'(acc_q.size() != 0), 1);
      if (acc_q.size() != 0) begin
        e = acc_q.pop_front();
        chk("acc_write", 32'(bus.mem_write), 32'(e.write));
        chk("acc_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (e.write) chk("acc_wdata", 32'(bus.mem_data_in), 32'(e.wdata));
      end
      if (bus.mem_write) wr_edges.push_back(cyc + 1);
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      rsp_edges.push_back(cyc + 1);
      chk("rsp_width", 32'(prev_rsp), 0);
      chk("rsp_expected", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        chk("rsp_addr", 32'(bus.rsp_addr), 32'(e.addr));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.wdata));
      end
    end
    prev_rd  = bus.mem_read;
    prev_wr  = bus.mem_write;
    prev_rsp = bus.rsp_valid;
  end

  // issue one command (called at a negedge); d is write data or expected read data
  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d, output int stalls);
    mem_req_t e;
    stalls = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = w ? d : 8'h00;
    while (!bus.req_ready && stalls < 64) begin
      @(negedge clk);
      stalls++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'(bus.req_ready), 1);
    end else begin
      e.write = w; e.addr = a; e.wdata = d;
      acc_q.push_back(e);
      if (w) shadow[a] = d;
      else   rsp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      last_hs = cyc;
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0;
    while ((acc_q.size() != 0 || rsp_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int st, hs, cnt0, gap;
    int exp_st [8] = '{0, 0, 0, 0, 0, 1, 3, 1};
    logic w;
    logic [4:0] a;
    logic [7:0] d;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 32; i++) shadow[i] = 8'h00;

    // reset state
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_mem_read", 32'(bus.mem_read), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_data_in", 32'(bus.mem_data_in), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    rst_ = 1'b1;
    mem_init = 1'b0;
    @(negedge clk);

    // single write then read, with latency from an idle FSM
    wr_edges.delete();
    send(1'b1, 5'h0A, 8'h5C, st);
    hs = last_hs;
    drain();
    chk("wr_latency", 32'(wr_edges.size() == 1 ? wr_edges[0] - hs : -1), 2);
    rsp_edges.delete();
    send(1'b0, 5'h0A, 8'h5C, st);
    hs = last_hs;
    drain();
    chk("rd_latency", 32'(rsp_edges.size() == 1 ? rsp_edges[0] - hs : -1), 4);

    // FIFO full: two reads up front keep the FSM slow so six writes overrun it
    wr_edges.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 2) send(1'b0, 5'(5'h10 + i), 8'h00, st);
      else       send(1'b1, 5'(i - 2), 8'(8'hA0 + i - 2), st);
      chk("fill_stall", 32'(st), 32'(exp_st[i]));
    end
    drain();
    chk("fill_wr_count", 32'(wr_edges.size()), 6);
    for (int i = 1; i < 6; i++)
      if (i < wr_edges.size()) chk("fill_wr_spacing", 32'(wr_edges[i] - wr_edges[i-1]), 2);
    for (int i = 0; i < 6; i++) send(1'b0, 5'(i), 8'(8'hA0 + i), st);
    drain();

    // read-after-write ordering on one address
    send(1'b1, 5'h1F, 8'h11, st);
    send(1'b0, 5'h1F, 8'h11, st);
    send(1'b1, 5'h1F, 8'h22, st);
    send(1'b0, 5'h1F, 8'h22, st);
    drain();

    // reset during RD_WAIT with two reads still queued
    send(1'b0, 5'h1F, 8'h22, st);
    send(1'b0, 5'h1F, 8'h22, st);
    send(1'b0, 5'h1F, 8'h22, st);
    bus.req_valid = 1'b0;
    chk("busy_before_rst", 32'(bus.busy), 1);
    cnt0 = rsp_cnt;
    #2;
    rst_ = 1'b0;
    acc_q.delete();
    rsp_q.delete();
    #1;
    chk("midrst_mem_read", 32'(bus.mem_read), 0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_req_ready", 32'(bus.req_ready), 1);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_cnt), 32'(cnt0));
    send(1'b0, 5'h1F, 8'h22, st);
    drain();
    chk("midrst_next_rsp", 32'(rsp_cnt), 32'(cnt0 + 1));

    // random mix: exclusivity and strobe width checked by the monitor throughout
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = w ? 8'($urandom_range(0, 255)) : shadow[a];
      send(w, a, d, st);
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        bus.req_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    drain();
    chk("end_acc_q_empty", 32'(acc_q.size()), 0);
    chk("end_rsp_q_empty", 32'(rsp_q.size()), 0);
    chk("end_busy", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
